// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM states, frame constants and
// sizing helpers used by both the transmitter and the future receiver.
package uart_pkg;

    // Line-level frame phases; the receiver walks the same sequence.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

    localparam logic [UART_IDX_W-1:0] UART_LAST_BIT =
        UART_IDX_W'(UART_DATA_BITS - 1);

    // Baud counter width: enough to hold CLKS_PER_BIT, never zero.
    function automatic int baud_cnt_width(input int clks_per_bit);
        int w;
        w = $clog2(clks_per_bit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clocks within one bit and flags the last
// clock of the period so the FSM can advance on that edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_end = (count == LAST);

    // Free-run 0..LAST and wrap; held at zero while the line is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per tx_start while idle and
// shifts it out LSB first between a low start bit and a high stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clk_freq  = 50_000_000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = clk_freq / baud_rate;

    if (CLKS_PER_BIT < 1) begin : g_cfg_err
        $error("uart_tx: clk_freq/baud_rate must be at least 1");
    end

    uart_state_t state;
    uart_state_t state_n;

    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] shreg_n;
    logic [UART_IDX_W-1:0]     bit_idx;
    logic [UART_IDX_W-1:0]     bit_idx_n;

    logic line_n;
    logic busy_n;
    logic done_n;
    logic bit_end;
    logic baud_clear;

    // Timer restarts from zero on the accept edge because it is held
    // cleared for every cycle spent idle.
    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    // State, shift register and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx_line <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            tx_line <= line_n;
            tx_busy <= busy_n;
            tx_done <= done_n;
        end
    end

    // Next-state logic; the line is pre-loaded with the value for the
    // upcoming bit on the edge that ends the current one.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        line_n    = tx_line;
        busy_n    = tx_busy;
        done_n    = 1'b0;

        unique case (state)
            IDLE: begin
                line_n = 1'b1;
                busy_n = 1'b0;
                if (tx_start) begin
                    shreg_n   = data;
                    bit_idx_n = '0;
                    line_n    = 1'b0;
                    busy_n    = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    line_n  = shreg[0];
                    shreg_n = {1'b0, shreg[UART_DATA_BITS-1:1]};
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == UART_LAST_BIT) begin
                        line_n  = 1'b1;
                        state_n = STOP;
                    end else begin
                        line_n    = shreg[0];
                        shreg_n   = {1'b0, shreg[UART_DATA_BITS-1:1]};
                        bit_idx_n = bit_idx + UART_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line bits are queued when a
// frame is launched and popped at the middle of each bit period.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB   = 104;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx_line;
    logic       tx_busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_q[$];

    uart_tx #(
        .clk_freq (1_000_000),
        .baud_rate(9600)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .data    (data),
        .tx_line (tx_line),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #500 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(1'b1);
    endtask

    // Raise tx_start at a falling edge; return #1 after the accept edge.
    task automatic start_frame(input logic [7:0] d, input bit hold);
        @(negedge clk);
        data     = d;
        tx_start = 1'b1;
        push_frame(d);
        @(posedge clk);
        #1;
        if (!hold) tx_start = 1'b0;
        check("accept_line", {31'd0, tx_line}, 32'd0);
        check("accept_busy", {31'd0, tx_busy}, 32'd1);
    endtask

    // Follow one frame edge by edge from its accept edge.
    task automatic watch_frame(input bit restart, input bit inject);
        int dones    = 0;
        int done_at  = -1;
        int busy_bad = 0;
        bit b;
        for (int n = 1; n <= FRAME + 1; n++) begin
            @(posedge clk);
            #1;
            if (inject && n == 300) begin
                data     = 8'hFF;
                tx_start = 1'b1;
            end
            if (inject && n == 301) tx_start = 1'b0;
            if (n % CPB == CPB / 2) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    check("line_bit", {31'd0, tx_line}, {31'd0, b});
                end
            end
            if (n < FRAME && tx_busy !== 1'b1) busy_bad++;
            if (tx_done === 1'b1) begin
                dones++;
                done_at = n;
            end
            if (n == FRAME) begin
                check("end_busy", {31'd0, tx_busy}, 32'd0);
                check("end_line", {31'd0, tx_line}, 32'd1);
            end
            if (n == FRAME + 1) begin
                check("next_line", {31'd0, tx_line}, {31'd0, !restart});
                check("next_busy", {31'd0, tx_busy}, {31'd0, restart});
            end
        end
        check("done_count", dones, 32'd1);
        check("done_cycle", done_at, FRAME);
        check("busy_held", busy_bad, 32'd0);
    endtask

    initial begin
        #10;
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_line", {31'd0, tx_line}, 32'd1);
            check("rst_busy", {31'd0, tx_busy}, 32'd0);
            check("rst_done", {31'd0, tx_done}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_line", {31'd0, tx_line}, 32'd1);
        check("idle_busy", {31'd0, tx_busy}, 32'd0);
        check("idle_done", {31'd0, tx_done}, 32'd0);

        start_frame(8'hA5, 1'b0);
        watch_frame(1'b0, 1'b0);

        start_frame(8'h3C, 1'b0);
        watch_frame(1'b0, 1'b0);

        start_frame(8'h00, 1'b0);
        watch_frame(1'b0, 1'b1);
        check("inject_queue", exp_q.size(), 32'd0);

        start_frame(8'h96, 1'b0);
        repeat (300) @(posedge clk);
        #200;
        reset = 1'b1;
        #1;
        check("async_line", {31'd0, tx_line}, 32'd1);
        check("async_busy", {31'd0, tx_busy}, 32'd0);
        check("async_done", {31'd0, tx_done}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 2 * CPB; i++) begin
                @(posedge clk);
                #1;
                if (tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_line !== 1'b1)
                    bad++;
            end
            check("abort_quiet", bad, 32'd0);
        end

        start_frame(8'h55, 1'b1);
        watch_frame(1'b1, 1'b0);
        tx_start = 1'b0;
        push_frame(8'h55);
        watch_frame(1'b0, 1'b0);
        check("final_queue", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
